piso_tx: RTL
============

# piso_tx

Parallel-in, serial-out transmitter for the FIR sample path. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle, MSB first. The bit order matches the 4-bit serial-in capture register: after WIDTH enabled shifts, that register holds the original word unchanged. The shared `en` strobe sets the bit rate, so transmitter and receiver advance on the same edges.

## Interface
- WIDTH, 4, word length in bits; legal range ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- en  input  1  bit-rate strobe; a serial bit advances only on edges where en=1
- in_valid  input  1  in_data is valid
- in_ready  output  1  transmitter can accept a word this cycle
- in_data  input  WIDTH  parallel word to send
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a frame bit
- sout_last  output  1  sout carries the final (LSB) bit of the frame

## Operation
- States: IDLE and SHIFT.
- IDLE
  - in_ready=1, sout_valid=0, sout_last=0, sout holds its last value.
  - If in_valid=1, the word is loaded into shift register `sreg`, `cnt` is set to 0, and the state goes to SHIFT.
- SHIFT
  - sout=sreg[WIDTH-1] and sout_valid=1.
  - On an edge with en=1: sreg shifts left one place (0 fills the LSB) and cnt increments.
  - On an edge with en=0: sreg, cnt and the state all hold.
  - When cnt==WIDTH-1 and en=1, the frame ends and the state goes to IDLE.
- sout_last=1 exactly while in SHIFT with cnt==WIDTH-1.
- cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1; there is no wrap-around inside a frame.
- in_valid during SHIFT is ignored and in_ready=0, except as described under Configuration.
- Loading in IDLE does not depend on en.

## Timing
- Reset (rst=0 at a posedge) forces:
  - state=IDLE
  - sreg=0, cnt=0
  - sout=0, sout_valid=0, sout_last=0
  - in_ready=0 while rst=0
- Reset mid-frame aborts the frame immediately; no remaining bits are emitted.
- in_ready=1 from the first cycle after rst returns to 1.
- Accept edge t (in_valid & in_ready) → at t+1, sout=in_data[WIDTH-1] and sout_valid=1. Load latency is 1 cycle.
- Each bit stays on sout until the first subsequent edge with en=1. The receiver samples on that same edge.
- With en held at 1, a frame occupies exactly WIDTH cycles, and the minimum word period is WIDTH+1 cycles.
- Outputs are registered or decoded from registered state only. in_ready is combinational from state and rst, with no combinational path from in_valid.

## Configuration
- Macro: PISO_TX_BACKTOBACK_EN.
- Defined:
  - in_ready is also 1 in SHIFT when cnt==WIDTH-1 and en=1.
  - A word accepted on that edge reloads sreg, sets cnt=0 and keeps the state in SHIFT.
  - Frames stream with no gap, giving a word period of WIDTH cycles at en=1.
- Undefined:
  - in_ready=1 only in IDLE.
  - There is always at least one IDLE cycle between frames.

## Structure
- Shared package `fir_pkg`:
  - typedef enum logic [0:0] `piso_state_e` {PISO_IDLE, PISO_SHIFT}
  - localparam `FIR_SER_WIDTH = 4`, used as the default for WIDTH
- One small sub-module is natural: `piso_bitcnt`, a saturating bit counter with load, enable and terminal-count outputs.
- The FSM, sreg and output decode stay in piso_tx.

## Test plan
- After reset release, apply in_data=4'b1011, in_valid=1 for one cycle, en=1 constantly → sout=1,0,1,1 on the 4 following cycles, sout_valid=1 for those 4 cycles, sout_last=1 only on the 4th, then in_ready=1.
- Same word with en=1 only on every 3rd cycle → each bit is held 3 cycles, and the frame completes after 4 en pulses.
- Drive sout into the serial-in capture register with a shared en, send 4'b0110 → the capture register reads 4'b0110 after the 4th enabled edge.
- Assert rst=0 after 2 bits of 4'b1100 → next cycle sout=0, sout_valid=0, in_ready=0. After release, a new word 4'b0001 transmits correctly.
- Hold in_valid=1 with a second word 4'b0101 during a frame:
  - Undefined macro → word accepted only after one IDLE cycle.
  - Defined macro → first bit of 4'b0101 follows the previous LSB with no gap.
- WIDTH=8, send 8'hA5 → sout=1,0,1,0,0,1,0,1 and sout_last=1 on the 8th bit.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR sample path.
//   piso_state_e  - transmitter FSM state encoding
//   FIR_SER_WIDTH - default serial word length
//   cnt_width()   - bit width needed to count 0..w-1
package fir_pkg;

    typedef enum logic [0:0] {
        PISO_IDLE,
        PISO_SHIFT
    } piso_state_e;

    localparam int unsigned FIR_SER_WIDTH = 4;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// piso_tx_if: parallel-word handshake plus serial output bundle.
//   in_valid/in_ready/in_data - word handshake (master drives valid/data)
//   sout/sout_valid/sout_last - serial bit stream (slave drives)
// Modports: master = word source / serial sink, slave = transmitter.
interface piso_tx_if
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_SER_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  sout,
        input  sout_valid,
        input  sout_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output sout,
        output sout_valid,
        output sout_last
    );

endinterface

// File: rtl/piso_tx_bitcnt.sv
// piso_bitcnt: saturating bit counter for the serial transmitter.
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset (count -> 0)
//   load - force count to 0 (priority over inc)
//   inc  - advance count by one, saturating at MaxCnt
//   tc   - terminal count, high while count == MaxCnt
module piso_bitcnt
    import fir_pkg::*;
#(
    parameter int unsigned MaxCnt = 3,
    parameter int unsigned CntW   = cnt_width(MaxCnt + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic tc
);

    localparam logic [CntW-1:0] MaxVal = CntW'(MaxCnt);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == MaxVal);

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter, MSB first, one bit per en strobe.
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   en   - bit-rate strobe shared with the serial receiver
//   bus  - piso_tx_if.slave: word handshake in, sout/sout_valid/sout_last out
// Build option: define PISO_TX_BACKTOBACK_EN to accept the next word on the
// final bit's enabled edge, so frames stream with no IDLE gap.
module piso_tx
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_SER_WIDTH
) (
    input logic         clk,
    input logic         rst,
    input logic         en,
    piso_tx_if.slave    bus
);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             sout_q, sout_d;
    logic             cnt_load, cnt_inc, cnt_tc;
    logic             ready;
    logic             accept;
    logic             last_edge;

    piso_bitcnt #(
        .MaxCnt (WIDTH - 1),
        .CntW   (cnt_width(WIDTH))
    ) u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .inc  (cnt_inc),
        .tc   (cnt_tc)
    );

    // Edge on which the final (LSB) bit is consumed by the receiver.
    assign last_edge = (state_q == PISO_SHIFT) && cnt_tc && en;

`ifdef PISO_TX_BACKTOBACK_EN
    assign ready = rst && ((state_q == PISO_IDLE) || last_edge);
`else
    assign ready = rst && (state_q == PISO_IDLE);
`endif

    assign accept = bus.in_valid && ready;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            PISO_IDLE: begin
                if (accept) begin
                    sreg_d   = bus.in_data;
                    cnt_load = 1'b1;
                    state_d  = PISO_SHIFT;
                end
            end
            PISO_SHIFT: begin
                if (en) begin
                    if (cnt_tc) begin
                        // accept here is only possible in the back-to-back build
                        if (accept) begin
                            sreg_d   = bus.in_data;
                            cnt_load = 1'b1;
                        end else begin
                            sreg_d   = {sreg_q[WIDTH-2:0], 1'b0};
                            cnt_load = 1'b1;
                            state_d  = PISO_IDLE;
                        end
                    end else begin
                        sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_d = PISO_IDLE;
        endcase
    end

    // sout is registered so it holds its last value through IDLE.
    always_comb begin
        sout_d = sout_q;
        if (state_d == PISO_SHIFT) begin
            sout_d = sreg_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= PISO_IDLE;
            sreg_q  <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            sout_q  <= sout_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = (state_q == PISO_SHIFT);
    assign bus.sout_last  = (state_q == PISO_SHIFT) && cnt_tc;

endmodule
